// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter and instruction-fetch handshake sequencer
module pc_fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        run,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        redirect_valid,
  input  logic        redirect_abs,
  input  logic [15:0] redirect_value,
  input  logic        redirect_link,
  output logic        link_valid,
  output logic [15:0] link_addr,
  output logic [15:0] pc,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

  state_t      state;
  state_t      stateNext;
  logic        pendValid;
  logic [15:0] pendTarget;

  logic        acked;
  logic        redirTake;
  logic        deferNow;
  logic        applyNow;
  logic        deliver;
  logic        discard;
  logic        goFault;
  logic [15:0] target;

  // Relative offsets are in words, so the top offset bit falls off the shift.
  assign target    = redirect_abs ? redirect_value
                                  : pc + {redirect_value[14:0], 1'b0};
  assign acked     = (state == FETCH) && fetch_ack;
  assign redirTake = redirect_valid && (state != FAULT);
  // fetch_addr must not move under an un-acked request, so such redirects wait.
  assign deferNow  = redirTake && (state == FETCH) && !fetch_ack;
  assign applyNow  = redirTake && !deferNow;
  // An ack that lands while a redirect is pending carries a stale instruction.
  assign deliver   = acked && !pendValid;
  assign discard   = acked && pendValid;
  // A redirect applied this cycle supersedes whatever was pending.
  assign goFault   = applyNow ? target[0] : (discard && pendTarget[0]);

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state selection
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (goFault)  stateNext = FAULT;
        else if (run) stateNext = FETCH;
      end
      FETCH: begin
        if (goFault)    stateNext = FAULT;
        else if (acked) stateNext = run ? FETCH : IDLE;
      end
      FAULT:   stateNext = FAULT;
      default: stateNext = IDLE;
    endcase
  end

  // Memory-side handshake outputs
  always_comb begin
    fetch_req  = (state == FETCH);
    fetch_addr = pc;
  end

  // PC, pending redirect, delivered instruction, link and fault registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc          <= RESET_PC;
      pendValid   <= 1'b0;
      pendTarget  <= 16'h0000;
      instr_valid <= 1'b0;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      link_valid  <= 1'b0;
      link_addr   <= 16'h0000;
      fault       <= 1'b0;
    end else begin
      instr_valid <= deliver;
      link_valid  <= redirTake && redirect_link;

      if (deliver) begin
        instr    <= fetch_data;
        instr_pc <= pc;
      end

      if (redirTake && redirect_link) link_addr <= pc;

      if (deferNow) begin
        pendValid  <= 1'b1;
        pendTarget <= target;
      end else if (acked) begin
        pendValid <= 1'b0;
      end

      if (goFault) begin
        fault <= 1'b1;
      end else if (applyNow) begin
        pc <= target;
      end else if (discard) begin
        pc <= pendTarget;
      end else if (deliver) begin
        pc <= pc + 16'd2;
      end
    end
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the 16-bit program counter and drives the instruction-memory fetch handshake. It is the register side of the PC+2 incrementer datapath: it holds the current PC, advances it by 2 on every accepted fetch, and loads branch/jump targets from the control unit.
- Sits between the control unit (redirects, run) and instruction memory (req/ack). Delivers fetched instructions, tagged with their PC, to decode.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- run  in  1  1 = fetching permitted
- fetch_req  out  1  fetch request to instruction memory
- fetch_addr  out  16  fetch address; stable while fetch_req=1 and no ack yet
- fetch_ack  in  1  memory has data this cycle; ignored when fetch_req=0
- fetch_data  in  16  instruction word, valid with fetch_ack
- instr_valid  out  1  one-cycle pulse: instr/instr_pc valid
- instr  out  16  fetched instruction
- instr_pc  out  16  address the instr was fetched from
- redirect_valid  in  1  one-cycle redirect request
- redirect_abs  in  1  1 = absolute target, 0 = PC-relative
- redirect_value  in  16  absolute target, or signed word offset
- redirect_link  in  1  save return address with this redirect
- link_valid  out  1  one-cycle pulse: link_addr updated
- link_addr  out  16  saved return address
- pc  out  16  current PC register
- fault  out  1  sticky misaligned-target flag

Behaviour:
- Clocking and reset: one clock (CLK). Reset is synchronous, active-high, with priority over everything else.
- Reset values: pc=RESET_PC, state=IDLE, fetch_req=0, instr_valid=0, instr=0, instr_pc=0, link_valid=0, link_addr=0, fault=0, pending redirect cleared. Reset during an outstanding request abandons it: fetch_req=0 the next cycle.
- States: IDLE, FETCH, FAULT.
- IDLE:
  - fetch_req=0.
  - run=1 -> FETCH.
  - Redirects are accepted here; pc updates directly.
- FETCH:
  - fetch_req=1 and fetch_addr=pc.
  - On fetch_ack with no pending redirect:
    - instr<=fetch_data, instr_pc<=pc.
    - instr_valid=1 on the following cycle.
    - pc<=pc+2, modulo 2^16: 16'hFFFE -> 16'h0000.
  - After an ack, run=0 -> IDLE; otherwise stay in FETCH. Back-to-back acks give one instruction per cycle.
  - run dropping without an ack does not withdraw the request. The block stays in FETCH until the ack, then goes to IDLE.
- Redirect target computation (all modulo 2^16):
  - Relative: target = pc + {redirect_value[14:0],1'b0}, using the pc register value in the cycle redirect_valid is sampled.
  - Absolute: target = redirect_value.
- Link: if redirect_link=1, link_addr<=pc (the pre-redirect pc) and link_valid pulses one cycle. The link updates even when the redirect is deferred.
- Redirect with no outstanding un-acked request (IDLE, or FETCH in the same cycle as fetch_ack):
  - pc<=target; the redirect wins over +2.
  - A same-cycle acked instruction is still delivered (instr_valid=1) with its original instr_pc.
- Redirect while a request is outstanding and not acked:
  - fetch_addr must stay stable, so the target is stored in a pending register.
  - On the ack, the fetched word is discarded (no instr_valid) and pc<=pending target. The request re-issues at the new pc next cycle.
  - A second redirect before the ack overwrites the pending target.
- Misalignment: if the target has bit0=1 (absolute only):
  - fault<=1 and state<=FAULT; pc unchanged.
  - If a request is outstanding, wait for its ack, discard the data, then enter FAULT.
- FAULT: fetch_req=0; redirects and run are ignored; fault stays 1 until Reset.
- redirect_valid in the FAULT state has no effect, including no link update.

Test Plan:
- Reset -> pc=0, fetch_req=0, fault=0. Then run=1 with ack every cycle, data 16'h1111/2222/3333 -> instr_pc 0,2,4 with matching instr, one instr_valid pulse each, pc=6.
- Wrap: RESET_PC=16'hFFFC, run=1, ack every cycle -> fetch_addr FFFC, FFFE, 0000.
- Relative redirect:
  - pc=16'hAAAE with offset 16'h0001 in IDLE -> pc=16'hAAB0.
  - offset 16'hFFFF -> pc=16'hAAAC.
  - with redirect_link=1 -> link_addr=16'hAAAE and link_valid pulse.
- Deferred redirect: fetch_req pending at 16'h0010 with ack delayed 3 cycles; redirect abs 16'h0200 on cycle 1 -> fetch_addr held at 0010, then ack, no instr_valid, next fetch_addr=16'h0200.
- Simultaneous ack and redirect abs 16'h0100 at pc=16'h0020 -> instr_valid with instr_pc=16'h0020, then fetch_addr=16'h0100.
- Misaligned redirect abs 16'h0301 -> fault=1 next cycle, fetch_req=0, later redirects ignored. Reset clears fault and pc=RESET_PC.
